// File: rtl/sm_accumulator_if.sv
// Handshake and data bundle between a neuron-accumulator client and the accumulator.
// No latency of its own; it only groups the wires.
// The master drives start/bias/in_valid/in_data. The slave answers with in_ready, busy, out_valid and result.
interface sm_accumulator_if;
  logic        start;
  logic [20:0] bias;
  logic        in_valid;
  logic [20:0] in_data;
  logic        in_ready;
  logic        busy;
  logic        out_valid;
  logic [20:0] result;

  modport master (
    output start, bias, in_valid, in_data,
    input  in_ready, busy, out_valid, result
  );

  modport slave (
    input  start, bias, in_valid, in_data,
    output in_ready, busy, out_valid, result
  );
endinterface

// File: rtl/sm_accumulator.sv
// Sign-magnitude neuron accumulator: bias plus N_INPUTS product terms, then an optional ReLU.
// Latency: out_valid is high N_INPUTS+1 cycles after the accepted start cycle, plus one cycle per stalled beat.
// Backpressure: in_ready is high only in ACC. Beats with in_valid low are simply waited for, and start is ignored while busy.
module sm_accumulator #(
  parameter int N_INPUTS = 62,
  parameter bit RELU_EN  = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  sm_accumulator_if.slave acc_if
);

  localparam int CW = $clog2(N_INPUTS) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N_INPUTS - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t        state;
  logic [20:0]   acc;
  logic [CW-1:0] cnt;
  logic [20:0]   result_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          in_ready_q;
  logic          beat;
  logic [20:0]   acc_next;

  // Any zero magnitude is forced to +0 so that -0 never escapes the block.
  function automatic logic [20:0] sm_canon(input logic [20:0] v);
    return (v[19:0] == 20'd0) ? 21'd0 : v;
  endfunction

  // Sign-magnitude add. A same-sign sum saturates at full scale. A mixed-sign sum takes the sign of the larger magnitude.
  function automatic logic [20:0] sm_add(input logic [20:0] a, input logic [20:0] b);
    logic [20:0] sum;
    logic [20:0] r;
    sum = {1'b0, a[19:0]} + {1'b0, b[19:0]};
    if (a[20] == b[20]) begin
      r = {a[20], (sum[20] ? 20'hFFFFF : sum[19:0])};
    end else if (a[19:0] >= b[19:0]) begin
      r = {a[20], a[19:0] - b[19:0]};
    end else begin
      r = {b[20], b[19:0] - a[19:0]};
    end
    return sm_canon(r);
  endfunction

  // Optional ReLU applied only to the value that gets published.
  function automatic logic [20:0] finish_val(input logic [20:0] v);
    return (RELU_EN && v[20]) ? 21'd0 : v;
  endfunction

  // A beat is consumed only when the FSM is in ACC and the client offers data.
  assign beat     = acc_if.in_valid && in_ready_q;
  assign acc_next = sm_add(acc, acc_if.in_data);

  // Control FSM. All outputs are registered next to the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= 21'd0;
      cnt         <= '0;
      result_q    <= 21'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid_q <= 1'b0;
          if (acc_if.start) begin
            acc        <= sm_canon(acc_if.bias);
            cnt        <= '0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
            state      <= ACC;
          end
        end
        ACC: begin
          if (beat) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              result_q    <= finish_val(acc_next);
              state       <= DONE;
            end
          end
        end
        DONE: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign acc_if.in_ready  = in_ready_q;
  assign acc_if.busy      = busy_q;
  assign acc_if.out_valid = out_valid_q;
  assign acc_if.result    = result_q;

endmodule

// File: tb/tb_sm_accumulator.sv
// Directed bench for sm_accumulator with N_INPUTS=3. One instance has ReLU enabled and one does not, and both see the same stimulus.
// An integer reference model is checked against both instances on every cycle.
// Each case also checks hand-computed literal results and the measured latency.
module tb_sm_accumulator;
  localparam int N = 3;
  localparam int FS = 1048575;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   misc = 0;
  bit   chk_en = 1'b0;

  sm_accumulator_if if_r ();
  sm_accumulator_if if_l ();

  sm_accumulator #(.N_INPUTS(N), .RELU_EN(1'b1)) dut_relu (.clk(clk), .rst(rst), .acc_if(if_r));
  sm_accumulator #(.N_INPUTS(N), .RELU_EN(1'b0)) dut_lin  (.clk(clk), .rst(rst), .acc_if(if_l));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Convert a sign-magnitude word to an integer.
  function automatic int smval(input logic [20:0] v);
    int m;
    m = int'({12'd0, v[19:0]});
    return v[20] ? -m : m;
  endfunction

  // Convert an integer to a sign-magnitude word, with zero always encoded as +0.
  function automatic logic [20:0] enc(input int s);
    logic [20:0] r;
    if (s < 0) r = {1'b1, 20'(-s)};
    else       r = {1'b0, 20'(s)};
    return r;
  endfunction

  function automatic int clamp(input int s);
    if (s > FS) return FS;
    if (s < -FS) return -FS;
    return s;
  endfunction

  task automatic check(input string nm, input logic [20:0] act, input logic [20:0] exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic [20:0] b, input logic v, input logic [20:0] d);
    if_r.start = st; if_r.bias = b; if_r.in_valid = v; if_r.in_data = d;
    if_l.start = st; if_l.bias = b; if_l.in_valid = v; if_l.in_data = d;
  endtask

  // Reference model. It holds a job phase, the number of beats left and a running integer sum.
  int          m_phase = 0;  // 0 idle, 1 collecting, 2 publishing
  int          m_left  = 0;
  int          m_sum   = 0;
  logic [20:0] m_res_r = 21'd0;
  logic [20:0] m_res_l = 21'd0;

  always @(posedge clk) begin
    int ns;
    if (rst) begin
      m_phase <= 0; m_left <= 0; m_sum <= 0; m_res_r <= 21'd0; m_res_l <= 21'd0;
    end else if (m_phase == 0) begin
      if (if_r.start) begin
        m_sum <= smval(if_r.bias); m_left <= N; m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      if (if_r.in_valid) begin
        ns = clamp(m_sum + smval(if_r.in_data));
        m_sum  <= ns;
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_phase <= 2;
          m_res_l <= enc(ns);
          m_res_r <= (ns < 0) ? 21'd0 : enc(ns);
        end
      end
    end else begin
      m_phase <= 0;
    end
  end

  // Compare both instances against the model on every cycle, sampling away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy_r",      21'(if_r.busy),      21'(m_phase != 0));
      check("in_ready_r",  21'(if_r.in_ready),  21'(m_phase == 1));
      check("out_valid_r", 21'(if_r.out_valid), 21'(m_phase == 2));
      check("result_r",    if_r.result,         m_res_r);
      check("busy_l",      21'(if_l.busy),      21'(m_phase != 0));
      check("out_valid_l", 21'(if_l.out_valid), 21'(m_phase == 2));
      check("result_l",    if_l.result,         m_res_l);
    end
  end

  // One accumulation. Junk data is offered in the start cycle and the DONE cycle, and start is also raised in the DONE cycle.
  // When stalls > 0, in_valid drops between beats while start is pulsed.
  task automatic run_case(input string nm, input logic [20:0] b, input logic [20:0] d0,
                          input logic [20:0] d1, input logic [20:0] d2, input int stalls,
                          input logic [20:0] er, input logic [20:0] el, input int elat);
    logic [20:0] d [3];
    int t0;
    int waited;
    d = '{d0, d1, d2};
    @(negedge clk);
    drive(1'b1, b, 1'b1, 21'h000100);
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        for (int s = 0; s < stalls; s++) begin
          @(negedge clk);
          drive(1'b1, 21'h000777, 1'b0, 21'h000000);
        end
      end
      @(negedge clk);
      drive(1'b0, 21'h000000, 1'b1, d[i]);
    end
    @(negedge clk);
    drive(1'b1, 21'h000009, 1'b1, 21'h0000FF);
    waited = 0;
    while (!if_r.out_valid && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    if (!if_r.out_valid) begin
      misc++;
      $display("FAIL %s_timeout: out_valid never seen within 30 cycles", nm);
    end
    check({nm, "_res_relu"}, if_r.result, er);
    check({nm, "_res_lin"},  if_l.result, el);
    check({nm, "_latency"},  21'(cyc - t0), 21'(elat));
    @(negedge clk);
    drive(1'b0, 21'h000000, 1'b0, 21'h000000);
    check({nm, "_start_in_done_ignored"}, 21'(if_r.busy), 21'd0);
    @(negedge clk);
  endtask

  initial begin
    drive(1'b0, 21'h0, 1'b0, 21'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy",     21'(if_r.busy),     21'd0);
    check("reset_in_ready", 21'(if_r.in_ready), 21'd0);
    check("reset_result",   if_l.result,        21'd0);
    chk_en = 1'b1;

    run_case("basic",    21'h000005, 21'h000003, 21'h000002, 21'h000001, 0, 21'h00000B, 21'h00000B, 4);
    run_case("relu",     21'h000001, 21'h100004, 21'h000001, 21'h000001, 0, 21'h000000, 21'h100001, 4);
    run_case("sat_pos",  21'h0FFFFF, 21'h000001, 21'h000001, 21'h000000, 0, 21'h0FFFFF, 21'h0FFFFF, 4);
    run_case("cancel",   21'h100007, 21'h000007, 21'h100000, 21'h000000, 0, 21'h000000, 21'h000000, 4);
    run_case("neg_zero", 21'h100000, 21'h000000, 21'h000000, 21'h100000, 0, 21'h000000, 21'h000000, 4);
    run_case("sat_neg",  21'h1FFFFF, 21'h100005, 21'h000003, 21'h000000, 0, 21'h000000, 21'h1FFFFC, 4);
    run_case("stall",    21'h000000, 21'h000001, 21'h000002, 21'h000003, 2, 21'h000006, 21'h000006, 8);

    // Reset in the middle of an accumulation, after two accepted beats.
    @(negedge clk);
    drive(1'b1, 21'h000000, 1'b0, 21'h0);
    @(negedge clk);
    drive(1'b0, 21'h000000, 1'b1, 21'h000001);
    @(negedge clk);
    drive(1'b0, 21'h000000, 1'b1, 21'h000001);
    @(negedge clk);
    drive(1'b0, 21'h000000, 1'b0, 21'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy",     21'(if_r.busy),     21'd0);
    check("midrst_in_ready", 21'(if_r.in_ready), 21'd0);
    check("midrst_result",   if_l.result,        21'd0);
    repeat (4) @(negedge clk);

    run_case("after_rst", 21'h000002, 21'h000001, 21'h000001, 21'h000001, 0, 21'h000005, 21'h000005, 4);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
